// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - key-driven move sequencer: issue, settle, commit resolved position, step cooldown
module player_move_ctrl #(
  parameter int START_X       = 1,
  parameter int START_Y       = 1,
  parameter int X_MAX         = 14,
  parameter int Y_MAX         = 19,
  parameter int SETTLE_CYCLES = 2,
  parameter int STEP_TICKS    = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_left,
  input  logic       key_down,
  input  logic [1:0] map_sel,
  input  logic [4:0] resolved_x,
  input  logic [4:0] resolved_y,
  output logic [2:0] move_out,
  output logic [4:0] query_x,
  output logic [4:0] query_y,
  output logic [4:0] player_x,
  output logic [4:0] player_y,
  output logic       step_done,
  output logic       blocked
);

  localparam int CNT_W = $clog2(STEP_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_COMMIT, S_COOLDOWN
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       key_meta, key_sync;  // {down, left, up, right}
  logic [2:0]       code_sel, code_q;
  logic [CNT_W-1:0] cool_cnt;
  logic [3:0]       settle_cnt;
  logic [1:0]       map_q;
  logic             map_valid;
  logic             map_chg;
  logic             res_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= {key_down, key_left, key_up, key_right};
      key_sync <= key_meta;
    end
  end

  always_comb begin
    code_sel = 3'b000;
    if (key_sync[0])      code_sel = 3'b100;
    else if (key_sync[1]) code_sel = 3'b001;
    else if (key_sync[2]) code_sel = 3'b010;
    else if (key_sync[3]) code_sel = 3'b011;
  end

  // map_q is only meaningful after the first post-reset edge has captured map_sel
  assign map_chg = map_valid && (map_sel != map_q);

  // an unchanged position means the detector hit a wall; 0-1 wraps to 31 and lands out of bounds
  assign res_ok = !(((resolved_x == player_x) && (resolved_y == player_y)) ||
                    (resolved_x > 5'(X_MAX)) || (resolved_y > 5'(Y_MAX)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if ((cool_cnt == '0) && (|key_sync)) state_nx = S_ISSUE;
      S_ISSUE:    state_nx = S_SETTLE;
      S_SETTLE:   if (settle_cnt == 4'(SETTLE_CYCLES - 1)) state_nx = S_COMMIT;
      S_COMMIT:   state_nx = S_COOLDOWN;
      S_COOLDOWN: if (cool_cnt <= CNT_W'(1)) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
    if (map_chg) state_nx = S_IDLE;
  end

  // move_out drops to 000 outside a move so a repeated direction still gives the detector an edge
  always_comb begin
    move_out = 3'b000;
    if ((state == S_ISSUE) || (state == S_SETTLE) || (state == S_COMMIT)) move_out = code_q;
  end

  assign query_x = player_x;
  assign query_y = player_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_x   <= 5'(START_X);
      player_y   <= 5'(START_Y);
      cool_cnt   <= '0;
      settle_cnt <= '0;
      code_q     <= 3'b000;
      step_done  <= 1'b0;
      blocked    <= 1'b0;
      map_q      <= 2'b00;
      map_valid  <= 1'b0;
    end else begin
      step_done <= 1'b0;
      blocked   <= 1'b0;
      map_valid <= 1'b1;
      map_q     <= map_sel;
      if (map_chg) begin
        player_x   <= 5'(START_X);
        player_y   <= 5'(START_Y);
        cool_cnt   <= '0;
        settle_cnt <= '0;
      end else begin
        case (state)
          S_IDLE:   if ((cool_cnt == '0) && (|key_sync)) code_q <= code_sel;
          S_ISSUE:  settle_cnt <= '0;
          S_SETTLE: settle_cnt <= settle_cnt + 4'd1;
          S_COMMIT: begin
            cool_cnt <= CNT_W'(STEP_TICKS - 1);
            if (res_ok) begin
              player_x  <= resolved_x;
              player_y  <= resolved_y;
              step_done <= 1'b1;
            end else begin
              blocked <= 1'b1;
            end
          end
          S_COOLDOWN: if (cool_cnt != '0) cool_cnt <= cool_cnt - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb/tb_player_move_ctrl.sv - table, directed and randomized checks of player_move_ctrl against a timestamp model
module tb_player_move_ctrl;
  localparam int S = 2, STEP = 4, SX = 1, SY = 1, XM = 14, YM = 19;

  logic clk = 0, reset = 1;
  logic key_right = 0, key_up = 0, key_left = 0, key_down = 0;
  logic [1:0] map_sel = 0;
  logic [4:0] resolved_x, resolved_y;
  logic [4:0] res_x_v = 0, res_y_v = 0;
  logic det_auto = 0;
  logic [2:0] move_out;
  logic [4:0] query_x, query_y, player_x, player_y;
  logic step_done, blocked;
  int total = 0, bad = 0;
  bit model_on = 0;

  player_move_ctrl #(.START_X(SX), .START_Y(SY), .X_MAX(XM), .Y_MAX(YM),
                     .SETTLE_CYCLES(S), .STEP_TICKS(STEP)) dut (
    .clk(clk), .reset(reset), .key_right(key_right), .key_up(key_up),
    .key_left(key_left), .key_down(key_down), .map_sel(map_sel),
    .resolved_x(resolved_x), .resolved_y(resolved_y), .move_out(move_out),
    .query_x(query_x), .query_y(query_y), .player_x(player_x), .player_y(player_y),
    .step_done(step_done), .blocked(blocked));

  initial forever #5 clk = ~clk;

  // wall-free detector when det_auto is set, otherwise fixed answers from res_*_v
  always_comb begin
    resolved_x = res_x_v;
    resolved_y = res_y_v;
    if (det_auto) begin
      resolved_x = query_x;
      resolved_y = query_y;
      case (move_out)
        3'b100: resolved_x = query_x + 5'd1;
        3'b010: resolved_x = query_x - 5'd1;
        3'b001: resolved_y = query_y - 5'd1;
        3'b011: resolved_y = query_y + 5'd1;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] prio(input logic [3:0] k);
    if (k[0]) return 3'b100;
    if (k[1]) return 3'b001;
    if (k[2]) return 3'b010;
    if (k[3]) return 3'b011;
    return 3'b000;
  endfunction

  // Model: moves are timestamps. A decision at cycle d (key seen two cycles late) gives ISSUE at d+1,
  // COMMIT at d+2+S, pulse at d+3+S, and the next decision no earlier than d+2+S+STEP.
  int mc, iss, pulse_c, free_at, mx, my, em, esd, ebl;
  bit pulse_step, mq_ok;
  logic [2:0] mcode;
  logic [1:0] mq;
  logic [3:0] kd1, kd2, keys_now;

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      if (reset) begin
        check("rst_move", move_out, 0);
        check("rst_x", player_x, SX);
        check("rst_y", player_y, SY);
        check("rst_pulses", step_done | blocked, 0);
        mc = 0; iss = -1; pulse_c = -1; free_at = 0; mx = SX; my = SY;
        mq_ok = 0; kd1 = 0; kd2 = 0;
      end else begin
        em  = (iss >= 0 && mc >= iss && mc <= iss + 1 + S) ? int'(mcode) : 0;
        esd = (mc == pulse_c && pulse_step) ? 1 : 0;
        ebl = (mc == pulse_c && !pulse_step) ? 1 : 0;
        check("model_move", move_out, em);
        check("model_x", player_x, mx);
        check("model_y", player_y, my);
        check("model_query", {query_x, query_y}, {mx[4:0], my[4:0]});
        check("model_step", step_done, esd);
        check("model_blocked", blocked, ebl);
        keys_now = {key_down, key_left, key_up, key_right};
        if (mq_ok && map_sel != mq) begin
          iss = -1; pulse_c = -1; mx = SX; my = SY; free_at = mc + 1; mq = map_sel;
        end else begin
          if (!mq_ok) begin mq = map_sel; mq_ok = 1; end
          if (iss >= 0 && mc == iss + 1 + S) begin
            if ((resolved_x == mx && resolved_y == my) || resolved_x > XM || resolved_y > YM)
              pulse_step = 0;
            else begin
              pulse_step = 1; mx = resolved_x; my = resolved_y;
            end
            pulse_c = mc + 1;
          end
          if (mc >= free_at && kd2 != 0) begin
            mcode = prio(kd2); iss = mc + 1; free_at = mc + 2 + S + STEP;
          end
        end
        kd2 = kd1; kd1 = keys_now; mc++;
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    {key_down, key_left, key_up, key_right} = 4'b0;
    reset = 1;
    next();
    next();
    reset = 0;
  endtask

  task automatic pulse_key(input logic [3:0] k, input int hold, input int ncyc,
                           output int n_sd, output int n_bl, output int code1);
    n_sd = 0; n_bl = 0; code1 = 0;
    for (int i = 0; i < ncyc; i++) begin
      {key_down, key_left, key_up, key_right} = (i < hold) ? k : 4'b0;
      @(negedge clk);
      n_sd += int'(step_done);
      n_bl += int'(blocked);
      if (code1 == 0 && move_out != 0) code1 = int'(move_out);
      next();
    end
  endtask

  typedef struct {
    logic [3:0] keys;
    int rx, ry, code, ex, ey, sd, bl;
  } vec_t;
  vec_t vt[12];

  logic [2:0] mo[24];
  logic       sdv[24], blv[24];
  logic [4:0] pxv[24], pyv[24];
  int nsd, nbl, c1, r1, r2, cnt;

  task automatic record(input int n, input int rel_right, input int rel_down, input int map_at);
    for (int i = 0; i < n; i++) begin
      if (i == rel_right) key_right = 0;
      if (i == rel_down) key_down = 0;
      if (i == map_at) map_sel = 2'b10;
      @(negedge clk);
      mo[i] = move_out; sdv[i] = step_done; blv[i] = blocked;
      pxv[i] = player_x; pyv[i] = player_y;
      next();
    end
  endtask

  initial begin
    vt[0]  = '{4'b0001, 2, 1, 4, 2, 1, 1, 0};
    vt[1]  = '{4'b0010, 1, 1, 1, 1, 1, 0, 1};
    vt[2]  = '{4'b0100, 0, 1, 2, 0, 1, 1, 0};
    vt[3]  = '{4'b1000, 1, 2, 3, 1, 2, 1, 0};
    vt[4]  = '{4'b1001, 2, 1, 4, 2, 1, 1, 0};
    vt[5]  = '{4'b0110, 1, 0, 1, 1, 0, 1, 0};
    vt[6]  = '{4'b1100, 31, 1, 2, 1, 1, 0, 1};
    vt[7]  = '{4'b1000, 1, 20, 3, 1, 1, 0, 1};
    vt[8]  = '{4'b1111, 15, 1, 4, 1, 1, 0, 1};
    vt[9]  = '{4'b0001, 14, 1, 4, 14, 1, 1, 0};
    vt[10] = '{4'b1000, 1, 19, 3, 1, 19, 1, 0};
    vt[11] = '{4'b1010, 1, 0, 1, 1, 0, 1, 0};

    model_on = 1;
    reset = 1;
    next();
    next();
    reset = 0;

    // idle after reset
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt += int'(step_done | blocked | (move_out != 0));
      next();
    end
    check("idle_activity", cnt, 0);
    check("idle_pos", {player_x, player_y}, {5'd1, 5'd1});

    // single right step timing
    do_reset(); det_auto = 1;
    key_right = 1;
    record(9, 99, 99, 99);
    key_right = 0;
    check("b_pre_issue", mo[2], 0);
    check("b_issue", mo[3], 4);
    check("b_commit_hold", mo[6], 4);
    check("b_px_at_commit", pxv[6], 1);
    check("b_after_commit", mo[7], 0);
    check("b_step_done", sdv[7], 1);
    check("b_px", pxv[7], 2);

    // blocked up at y=1, repeat spacing
    do_reset(); det_auto = 0; res_x_v = 1; res_y_v = 1;
    key_up = 1;
    record(24, 99, 99, 99);
    key_up = 0;
    r1 = -1; r2 = -1;
    for (int i = 1; i < 24; i++)
      if (mo[i] != 0 && mo[i-1] == 0) begin
        if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
      end
    check("c_first_issue", r1, 3);
    check("c_retry_gap", r2 - r1, 2 + S + STEP);
    check("c_blocked", blv[7], 1);
    check("c_gap_zero", mo[9], 0);
    check("c_pos", {pxv[23], pyv[23]}, {5'd1, 5'd1});

    // left at x=0 wraps to 31 and is rejected
    do_reset(); det_auto = 0; res_x_v = 0; res_y_v = 1;
    pulse_key(4'b0100, 3, 14, nsd, nbl, c1);
    check("d_reach_x0", player_x, 0);
    res_x_v = 31;
    pulse_key(4'b0100, 3, 14, nsd, nbl, c1);
    check("d_wrap_blocked", nbl, 1);
    check("d_wrap_no_step", nsd, 0);
    check("d_wrap_x", player_x, 0);

    // right+down held, right released mid-settle
    do_reset(); det_auto = 1;
    key_right = 1; key_down = 1;
    record(12, 4, 5, 99);
    check("e_code", mo[3], 4);
    check("e_code_held", mo[5], 4);
    check("e_step", sdv[7], 1);
    check("e_pos", {pxv[7], pyv[7]}, {5'd2, 5'd1});

    // map change during settle
    do_reset(); det_auto = 1;
    pulse_key(4'b0001, 3, 14, nsd, nbl, c1);
    check("f_pre_x", player_x, 2);
    key_right = 1;
    record(12, 3, 99, 4);
    check("f_settle_code", mo[4], 4);
    check("f_pos_reset", {pxv[5], pyv[5]}, {5'd1, 5'd1});
    check("f_move_clear", mo[5], 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) cnt += int'(sdv[i] | blv[i]) + ((i > 5 && mo[i] != 0) ? 1 : 0);
    check("f_quiet", cnt, 0);

    // table vectors, each from the start cell
    for (int v = 0; v < 12; v++) begin
      do_reset(); det_auto = 0; res_x_v = 5'(vt[v].rx); res_y_v = 5'(vt[v].ry);
      pulse_key(vt[v].keys, 3, 14, nsd, nbl, c1);
      check($sformatf("vec%0d_code", v), c1, vt[v].code);
      check($sformatf("vec%0d_step", v), nsd, vt[v].sd);
      check($sformatf("vec%0d_blocked", v), nbl, vt[v].bl);
      check($sformatf("vec%0d_x", v), player_x, vt[v].ex);
      check($sformatf("vec%0d_y", v), player_y, vt[v].ey);
    end

    // random traffic, compared cycle by cycle against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset = 0;
      if ($urandom_range(0, 5) == 0) {key_down, key_left, key_up, key_right} = 4'($urandom_range(0, 15));
      det_auto = ($urandom_range(0, 3) != 0);
      res_x_v = 5'($urandom_range(0, 31));
      res_y_v = 5'($urandom_range(0, 21));
      if ($urandom_range(0, 150) == 0) map_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 600) == 0) reset = 1;
      next();
    end
    reset = 0;
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Sequential front end of the movement path. Turns direction keys into the 3-bit move code consumed by the collision detector, holds that code stable while the detector resolves, then commits the resolved coordinates into the player position registers.
- Rate-limits steps and resets the player to the start cell whenever the selected map changes.
- Sits between the keyboard/KEY input logic and the collision detector; the renderer reads player_x/player_y.

Parameters:
- START_X, 1, player x coordinate after reset or map change.
- START_Y, 1, player y coordinate after reset or map change.
- X_MAX, 14, largest legal x coordinate (inclusive).
- Y_MAX, 19, largest legal y coordinate (inclusive).
- SETTLE_CYCLES, 2, cycles move_out is held before resolved_x/resolved_y are sampled (1..15).
- STEP_TICKS, 12500000, minimum clk cycles between consecutive committed steps (≥1; counter width is clog2(STEP_TICKS+1)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_right  in  1  asynchronous level, request move right.
- key_up  in  1  asynchronous level, request move up.
- key_left  in  1  asynchronous level, request move left.
- key_down  in  1  asynchronous level, request move down.
- map_sel  in  2  current map index; also forwarded to the detector.
- resolved_x  in  5  new x returned by the collision detector.
- resolved_y  in  5  new y returned by the collision detector.
- move_out  out  3  move code to the detector: 100 right, 001 up, 010 left, 011 down, 000 none.
- query_x  out  5  current position to the detector (equals player_x).
- query_y  out  5  current position to the detector (equals player_y).
- player_x  out  5  registered player x.
- player_y  out  5  registered player y.
- step_done  out  1  one-cycle pulse, position changed.
- blocked  out  1  one-cycle pulse, move rejected (wall or out of bounds).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - move_out=000; player_x=START_X, player_y=START_Y; step_done=0, blocked=0.
  - Cooldown counter=0; state=IDLE; map_q=map_sel is captured on the first clock edge after reset release.
- Key synchronisation: each key passes a 2-FF synchroniser. Decisions use the synchronised values only.
- Key priority when several are held: right > up > left > down.
- FSM states:
  - IDLE: move_out=000. If cooldown=0 and any synced key is high, load the move code and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: move_out=code (one cycle), then go to SETTLE.
  - SETTLE: move_out holds the code for SETTLE_CYCLES cycles, then go to COMMIT.
  - COMMIT: sample resolved_x/resolved_y; move_out still holds the code. Next state is COOLDOWN.
    - If the resolved value equals the current position, or resolved_x>X_MAX, or resolved_y>Y_MAX: keep the position and pulse blocked on the next cycle.
    - Otherwise: load the resolved value and pulse step_done on the next cycle.
    - The out-of-bounds check catches 0-1 wrapping to 31.
  - COOLDOWN: move_out=000. The cooldown counter was loaded with STEP_TICKS-1 in COMMIT. Decrement each cycle; go to IDLE when it reaches 0.
- move_out always returns to 000 between moves. This guarantees an edge for the detector's move-sensitive logic even when the same direction repeats.
- Step period with a key held continuously: one COMMIT every 2+SETTLE_CYCLES+STEP_TICKS cycles.
- Key released mid-move (ISSUE/SETTLE): the move still completes; the code is latched at IDLE exit.
- Map change (map_sel != map_q) in any state:
  - Next cycle: position=START, move_out=000, cooldown=0, state=IDLE, no step_done/blocked pulse, map_q updated.
  - This has priority over COMMIT in the same cycle.
- Asynchronous reset mid-move aborts immediately to the reset values.
- step_done and blocked are never high together.

Test Plan:
- Reset and release, no keys → player=(1,1), move_out=000, no pulses for 100 cycles.
- STEP_TICKS=4, SETTLE_CYCLES=2, resolved fed = current+1 in x, key_right held for one step:
  - Synced key seen → ISSUE the next cycle with move_out=100.
  - COMMIT 3 cycles after ISSUE.
  - player_x=2 and step_done high the cycle after COMMIT.
- key_up held at y=1, detector returns (1,1) → blocked pulse, player stays (1,1). Next attempt no sooner than STEP_TICKS cycles later; move_out visits 000 between attempts.
- key_left at x=0, detector returns x=31 → blocked, player_x stays 0.
- key_right and key_down held together → move_out=100 only; key_right released during SETTLE → step still commits.
- map_sel changes 00→10 during SETTLE → next cycle player=(1,1), move_out=000, state IDLE, no step_done.
